// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, JAL opcode,
// FSM state type and the J-type immediate extractor used by RVX_IF_JAL_PREDICT_EN.
package stage_if_pkg;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DRAIN
    } if_state_e;

    // J-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] jal_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// Instruction-memory request/grant + response-valid bus between the fetch stage
// (master) and instruction memory (slave).
interface stage_if_if #(
    parameter int unsigned BUS_W = 32
);
    logic             imemReqOut;
    logic [BUS_W-1:0] imemAddrOut;
    logic             imemGntIn;
    logic             imemRvalidIn;
    logic [BUS_W-1:0] imemRdataIn;

    modport master (
        output imemReqOut, imemAddrOut,
        input  imemGntIn, imemRvalidIn, imemRdataIn
    );

    modport slave (
        input  imemReqOut, imemAddrOut,
        output imemGntIn, imemRvalidIn, imemRdataIn
    );
endinterface

// File: rtl/stage_if_fetch_fifo.sv
// Fetch buffer holding {inst, pc} pairs; clear empties it but still accepts a
// word pushed in the same cycle.
module if_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 push_inst,
    input  logic [W-1:0]                 push_pc,
    output logic [W-1:0]                 head_inst,
    output logic [W-1:0]                 head_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     inst_mem [DEPTH];
    logic [W-1:0]     pc_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, wr_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_idx    = clear ? '0 : wr_ptr;
    assign head_inst = inst_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];
    assign empty     = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= push ? ptr_inc('0) : '0;
            count  <= CNT_W'(push);
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_idx] <= push_inst;
            pc_mem[wr_idx]   <= push_pc;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, credit-limited imem requests, fetch buffer and
// decode-facing output registers. Optional JAL self-redirect: RVX_IF_JAL_PREDICT_EN.
module stage_if
    import stage_if_pkg::*;
#(
    parameter int unsigned      BUS_W      = 32,
    parameter logic [BUS_W-1:0] RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirectIn,
    input  logic [BUS_W-1:0] redirectPcIn,
    stage_if_if.master       imem,
    output logic [BUS_W-1:0] instOut,
    output logic [BUS_W-1:0] pcOut,
    output logic [BUS_W-1:0] pcPlusOut,
    output logic             validOut
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    if_state_e        state, state_nxt;
    logic [BUS_W-1:0] pc, pc_nxt, push_pc, redirect_pc;
    logic [BUS_W-1:0] head_inst, head_pc;
    logic [CNT_W-1:0] outstanding, outstanding_nxt, fifo_count;
    logic             fifo_empty, grant, pop, push, clear, jal_taken, redirect_any;
    logic [31:0]      buffered;

    assign grant = imem.imemReqOut && imem.imemGntIn;
    assign pop   = !redirectIn && !flush && !stall && !fifo_empty;
`ifdef RVX_IF_JAL_PREDICT_EN
    assign jal_taken = pop && (head_inst[6:0] == OPCODE_JAL);
`else
    assign jal_taken = 1'b0;
`endif
    assign redirect_any = redirectIn || jal_taken;
    assign clear        = redirect_any || flush;
    assign push         = imem.imemRvalidIn && (state == ST_FETCH) && !redirect_any;

    // Outstanding requests are contiguous below pc, so the oldest one is pc - 4*outstanding
    assign push_pc = pc - (BUS_W'(outstanding) << 2);

    // Credit counts FIFO occupancy after this edge so a 1-cycle memory sustains full rate
    assign buffered         = (redirectIn || flush) ? 32'd0 : 32'(fifo_count) - 32'(pop);
    assign imem.imemReqOut  = (state == ST_FETCH) && ((buffered + 32'(outstanding)) < FIFO_DEPTH);
    assign imem.imemAddrOut = pc;

    always_comb begin
        redirect_pc = redirectPcIn & ~BUS_W'(3);
`ifdef RVX_IF_JAL_PREDICT_EN
        if (!redirectIn) redirect_pc = head_pc + BUS_W'($signed(jal_imm(head_inst[31:0])));
`endif
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(imem.imemRvalidIn);
        if (grant) pc_nxt = pc + BUS_W'(4);
        case (state)
            ST_BOOT:  state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_FETCH;
            ST_DRAIN: if (outstanding_nxt == '0) state_nxt = ST_FETCH;
            default:  state_nxt = ST_BOOT;
        endcase
        // Anything still in flight after a redirect is stale and must be drained
        if (redirect_any) begin
            pc_nxt    = redirect_pc;
            state_nxt = (outstanding_nxt != '0) ? ST_DRAIN : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            outstanding <= outstanding_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instOut   <= BUS_W'(NOP_INST);
            pcOut     <= '0;
            pcPlusOut <= BUS_W'(4);
            validOut  <= 1'b0;
        end else if (redirectIn || flush) begin
            instOut  <= BUS_W'(NOP_INST);
            validOut <= 1'b0;
        end else if (!stall) begin
            if (pop) begin
                instOut   <= head_inst;
                pcOut     <= head_pc;
                pcPlusOut <= head_pc + BUS_W'(4);
                validOut  <= 1'b1;
            end else begin
                instOut  <= BUS_W'(NOP_INST);
                validOut <= 1'b0;
            end
        end
    end

    if_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BUS_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_inst (imem.imemRdataIn),
        .push_pc   (push_pc),
        .head_inst (head_inst),
        .head_pc   (head_pc),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage directly upstream of the decode stage. Owns the program counter, issues in-order requests to instruction memory over a request/grant + response-valid handshake, buffers returned words in a small fetch FIFO, and presents one `{inst, pc, pc+4}` triple per cycle to decode. Handles pipeline stall, flush-to-bubble and PC redirect, including discarding stale in-flight responses.

## Interface
- `BUS_W`, 32, datapath/address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, fetch-buffer entries; also the max outstanding-plus-buffered credit
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `stall`  in  1  decode not accepting; output registers hold
- `flush`  in  1  replace output triple with a bubble next edge
- `redirectIn`  in  1  load new PC (branch/jump resolution)
- `redirectPcIn`  in  BUS_W  redirect target
- `imemReqOut`  out  1  fetch request
- `imemAddrOut`  out  BUS_W  fetch address (= PC register)
- `imemGntIn`  in  1  request accepted this cycle
- `imemRvalidIn`  in  1  response valid (in order, ≥1 cycle after grant)
- `imemRdataIn`  in  BUS_W  response instruction word
- `instOut`  out  BUS_W  instruction to decode
- `pcOut`  out  BUS_W  PC of `instOut`
- `pcPlusOut`  out  BUS_W  `pcOut + 4`
- `validOut`  out  1  output triple is a real instruction (0 = bubble)

## Operation
- FSM states: BOOT, FETCH, DRAIN.
  - BOOT: entered on reset; no request; next cycle → FETCH.
  - FETCH: `imemReqOut = 1` when `buffered + outstanding < FIFO_DEPTH`.
  - DRAIN: entered on redirect with `outstanding > 0` (after the redirect-cycle grant is counted); no requests; every `imemRvalidIn` discarded and decrements `dropCnt`; `dropCnt == 0` → FETCH. Redirect with zero outstanding goes straight to FETCH.
- Grant (`imemReqOut && imemGntIn`): PC += 4 (mod 2^BUS_W), `outstanding`++.
- Response in FETCH: push `{imemRdataIn, pcOfEntry}` into FIFO, `outstanding`--. FIFO tracks PCs in parallel via a pending-PC queue of depth FIFO_DEPTH.
- Output update when `!stall`: FIFO non-empty → pop to outputs, `validOut = 1`; empty → bubble (`instOut = 32'h0000_0013`, `validOut = 0`, `pcOut`/`pcPlusOut` hold).
- `flush` (any stall state): outputs ← bubble; FIFO cleared.
- `redirectIn`: PC ← `{redirectPcIn[BUS_W-1:2], 2'b00}`; FIFO cleared; `dropCnt` ← outstanding including any grant this cycle, minus any `imemRvalidIn` this cycle (that response is discarded).
- Priority: `rst` > `redirectIn` > `flush` > `stall` > normal. Redirect during DRAIN reloads PC and `dropCnt`; stays DRAIN.
- Credit rule guarantees a response never finds the FIFO full; no overflow path exists.

## Timing
- Reset values: PC = RESET_PC, state BOOT, `imemReqOut = 0`, `instOut = 32'h0000_0013`, `pcOut = 0`, `pcPlusOut = 4`, `validOut = 0`, FIFO empty, counters 0.
- First request one cycle after `rst` falls (cycle after BOOT).
- Response accepted at edge N → visible on outputs after edge N+1 (if not stalled); no bypass.
- Steady state with 1-cycle memory and no stall: one valid instruction per cycle.
- Redirect at edge N: request to new target in cycle N+1 if no stale responses outstanding; first new instruction on outputs no earlier than N+3.
- Reset asserted mid-drain or mid-request: all state returns to reset values; late responses after reset are a system error, not handled.

## Configuration
- `RVX_IF_JAL_PREDICT_EN` defined: when a JAL (opcode 7'b1101111) is popped to the outputs, the stage self-redirects to `pc + J-imm` with identical drop/clear behaviour as an external redirect; external `redirectIn` in the same cycle wins.
- Undefined: no decoding in this stage; JAL resolved downstream via `redirectIn`.

## Structure
- Shared package/include: NOP encoding `32'h0000_0013`, `OPCODE_JAL`, FSM state encoding; `BUS_W` from the existing global info include.
- One sub-module: `if_fetch_fifo` (parametric depth, `{inst, pc}` entries, push/pop/clear, count output).

## Test plan
- Reset release, 1-cycle memory, grant always: addresses 0x0,0x4,0x8 issued; outputs valid with pcOut 0x0,0x4,0x8 on consecutive cycles from cycle 3.
- Stall held 4 cycles: outputs frozen; requests stop after 2 buffered+outstanding; release → buffered words emerge in order, no loss.
- Redirect to 0x103 with 2 outstanding: next address 0x100; both stale responses dropped; first valid pcOut 0x100.
- Flush with full FIFO: next outputs `instOut = 0x00000013`, `validOut = 0`; FIFO empty.
- Redirect coincident with rvalid and grant: that response dropped, granted one counted stale; no stale word reaches outputs.
- With `RVX_IF_JAL_PREDICT_EN`, JAL +0x40 at pc 0x10: following valid pcOut 0x50; without macro, 0x14.
